// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: inverse S-box, GF(2^8) multipliers,
// FSM state encoding and the round-count legality check.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic bit nr_legal(input int nr);
    return (nr == 10) || (nr == 12) || (nr == 14);
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless this is the final round.
module inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [127:0] ark;
  logic [127:0] mixed;

  // Byte i = row + 4*col sits at [127-8i -: 8]; row r rotates right by r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign ark[127-8*(r+4*c) -: 8] =
        inv_sbox(state_in[127-8*(r+4*((c-r+4)%4)) -: 8]) ^ rk[127-8*(r+4*c) -: 8];
    end

    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[127-32*c -: 8];
    assign a1 = ark[119-32*c -: 8];
    assign a2 = ark[111-32*c -: 8];
    assign a3 = ark[103-32*c -: 8];

    assign mixed[127-32*c -: 8] = mul14(a0) ^ mul11(a1) ^ mul13(a2) ^ mul9(a3);
    assign mixed[119-32*c -: 8] = mul9(a0)  ^ mul14(a1) ^ mul11(a2) ^ mul13(a3);
    assign mixed[111-32*c -: 8] = mul13(a0) ^ mul9(a1)  ^ mul14(a2) ^ mul11(a3);
    assign mixed[103-32*c -: 8] = mul11(a0) ^ mul13(a1) ^ mul9(a2)  ^ mul14(a3);
  end

  assign state_out = last ? ark : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, round keys fetched
// from an external key store by index from NR down to 0.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for start; rk_idx=NR for the initial AddRoundKey
//   RUN     | full inverse rounds, rk_idx=cnt counting NR-1 down to 1
//   LAST    | final round without InvMixColumns, rk_idx=0; writes pt_out
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ct_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] pt_out,
  output logic         busy,
  output logic         done
);

  if (!nr_legal(NR)) begin : g_bad_nr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  state_e       fsm;
  logic [127:0] state;
  logic [3:0]   cnt;
  logic [127:0] round_out;

  always_comb begin
    rk_idx = 4'(NR);
    unique case (fsm)
      ST_IDLE: rk_idx = 4'(NR);
      ST_RUN:  rk_idx = cnt;
      ST_LAST: rk_idx = 4'd0;
      default: rk_idx = 4'(NR);
    endcase
  end

  inv_round u_round (
    .state_in  (state),
    .rk        (rk_in),
    .last      (fsm == ST_LAST),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm    <= ST_IDLE;
      state  <= '0;
      cnt    <= '0;
      pt_out <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (fsm)
        ST_IDLE: begin
          if (start) begin
            state <= ct_in ^ rk_in;
            cnt   <= 4'(NR - 1);
            busy  <= 1'b1;
            fsm   <= ST_RUN;
          end
        end
        ST_RUN: begin
          state <= round_out;
          if (cnt == 4'd1) begin
            cnt <= 4'd0;
            fsm <= ST_LAST;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_LAST: begin
          pt_out <= round_out;
          done   <= 1'b1;
          busy   <= 1'b0;
          fsm    <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: a forward AES model (S-box derived from GF
// inversion) produces ciphertexts whose plaintexts the DUT must recover.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_a = 1'b0;
  logic         start_b = 1'b0;
  logic [127:0] ct_in = '0;
  logic [3:0]   rk_idx_a, rk_idx_b;
  logic [127:0] rk_in_a, rk_in_b, pt_a, pt_b;
  logic         busy_a, busy_b, done_a, done_b;

  logic [127:0] ks_a [16];
  logic [127:0] ks_b [16];
  logic [7:0]   sbox [256];
  int           n_checks = 0;
  int           n_errors = 0;

  always #5 clk = ~clk;

  assign rk_in_a = ks_a[rk_idx_a];
  assign rk_in_b = ks_b[rk_idx_b];

  aes_inv_cipher_iter #(.NR(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ct_in(ct_in), .rk_idx(rk_idx_a),
    .rk_in(rk_in_a), .pt_out(pt_a), .busy(busy_a), .done(done_a)
  );

  aes_inv_cipher_iter #(.NR(14)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ct_in(ct_in), .rk_idx(rk_idx_b),
    .rk_in(rk_in_b), .pt_out(pt_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // key is left-aligned in 256 bits; Nk = NR-6 words.
  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) begin
      w[i] = key[255:224];
      key = key << 32;
    end
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nr == 14) ks_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          ks_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] rk_of(input int nr, input int r);
    return (nr == 14) ? ks_b[r] : ks_a[r];
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ rk_of(nr, 0);
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int i = 0; i < 16; i++) begin
        s[i] = blk[127:120];
        blk = blk << 8;
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = sbox[s[r+4*((c+r)%4)]];
      for (int c = 0; c < 4; c++) begin
        if (rnd != nr) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*c];
        end
      end
      for (int i = 0; i < 16; i++) blk = {blk[119:0], s[i]};
      blk ^= rk_of(nr, rnd);
    end
    return blk;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts one block, counts edges to done, optionally checks the key index walk.
  task automatic run_block(input string tag, input bit use_b, input logic [127:0] ct,
                           input logic [127:0] exp_pt, input bit chk_idx);
    int nr;
    int lat;
    nr = use_b ? 14 : 10;
    lat = 0;
    @(negedge clk);
    ct_in = ct;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    if (chk_idx) check({tag, " rk_idx pre"}, use_b ? rk_idx_b : rk_idx_a, 128'(nr));
    @(posedge clk); #1;
    check({tag, " busy after accept"}, use_b ? busy_b : busy_a, 1);
    for (int e = 1; e <= 40 && lat == 0; e++) begin
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      if (e == 1) ct_in = rand128();
      if (chk_idx) check($sformatf("%s rk_idx e%0d", tag, e), use_b ? rk_idx_b : rk_idx_a, 128'(nr - e));
      @(posedge clk); #1;
      if (use_b ? done_b : done_a) lat = e;
    end
    check({tag, " latency"}, 128'(lat), 128'(nr));
    check({tag, " pt_out"}, use_b ? pt_b : pt_a, exp_pt);
    check({tag, " busy at done"}, use_b ? busy_b : busy_a, 0);
    @(posedge clk); #1;
    check({tag, " done pulse width"}, use_b ? done_b : done_a, 0);
    check({tag, " pt_out holds"}, use_b ? pt_b : pt_a, exp_pt);
  endtask

  initial begin
    logic [127:0] pt_r, ct_r, ct_o;
    logic [255:0] key_r;
    int ndone, first_e;
    logic [127:0] pt_seen;
    int done_e [$];
    logic [127:0] done_pt [$];

    for (int i = 0; i < 16; i++) begin
      ks_a[i] = '0;
      ks_b[i] = '0;
    end
    build_sbox();

    repeat (2) @(posedge clk);
    #1;
    check("reset pt_out", pt_a, 0);
    check("reset busy", busy_a, 0);
    check("reset done", done_a, 0);
    check("reset rk_idx nr10", rk_idx_a, 10);
    check("reset rk_idx nr14", rk_idx_b, 14);
    #2 rst_n = 1'b1;

    // FIPS-197 C.1
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    check("model c1", encrypt(128'h00112233445566778899aabbccddeeff, 10),
          128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_block("c1", 1'b0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              128'h00112233445566778899aabbccddeeff, 1'b0);

    // FIPS-197 B with the key index walk
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10);
    run_block("appb", 1'b0, 128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 1'b1);

    for (int k = 0; k < 6; k++) begin
      key_r = {rand128(), 128'h0};
      expand(key_r, 10);
      pt_r = rand128();
      run_block($sformatf("rand10_%0d", k), 1'b0, encrypt(pt_r, 10), pt_r, 1'b0);
    end

    // start while busy
    key_r = {rand128(), 128'h0};
    expand(key_r, 10);
    pt_r = rand128();
    ct_r = encrypt(pt_r, 10);
    ct_o = ~ct_r;
    ndone = 0; first_e = 0; pt_seen = '0;
    @(negedge clk);
    ct_in = ct_r; start_a = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 30; e++) begin
      @(negedge clk);
      if (e >= 4 && e <= 6) begin
        start_a = 1'b1;
        ct_in = ct_o;
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
      if (done_a) begin
        ndone++;
        if (ndone == 1) first_e = e;
        pt_seen = pt_a;
      end
    end
    check("busy start ignored done count", 128'(ndone), 1);
    check("busy start ignored latency", 128'(first_e), 10);
    check("busy start ignored pt", pt_seen, pt_r);

    // back-to-back: vector B then C.1 key store needs both keys -> use B key for both
    expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 10);
    pt_r = rand128();
    ct_r = encrypt(pt_r, 10);
    @(negedge clk);
    ct_in = 128'h3925841d02dc09fbdc118597196a0b32; start_a = 1'b1;
    @(posedge clk);
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      if (e == 1) ct_in = ct_r;
      if (e == 12) start_a = 1'b0;
      @(posedge clk); #1;
      if (done_a) begin
        done_e.push_back(e);
        done_pt.push_back(pt_a);
      end
      if (e == 11) check("b2b accept in done cycle", busy_a, 1);
    end
    check("b2b done count", 128'(done_e.size()), 2);
    if (done_e.size() == 2) begin
      check("b2b first latency", 128'(done_e[0]), 10);
      check("b2b spacing", 128'(done_e[1] - done_e[0]), 11);
      check("b2b first pt", done_pt[0], 128'h3243f6a8885a308d313198a2e0370734);
      check("b2b second pt", done_pt[1], pt_r);
    end

    // async reset mid-operation
    pt_r = rand128();
    @(negedge clk);
    ct_in = encrypt(pt_r, 10); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async rst pt_out", pt_a, 0);
    check("async rst busy", busy_a, 0);
    check("async rst done", done_a, 0);
    check("async rst rk_idx", rk_idx_a, 10);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (done_a) ndone++;
    end
    check("async rst no done", 128'(ndone), 0);
    run_block("after rst", 1'b0, encrypt(pt_r, 10), pt_r, 1'b0);

    // NR=14, FIPS-197 C.3 plus random
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    run_block("c3", 1'b1, 128'h8ea2b7ca516745bfeafc49904b496089,
              128'h00112233445566778899aabbccddeeff, 1'b1);
    for (int k = 0; k < 2; k++) begin
      key_r = {rand128(), rand128()};
      expand(key_r, 14);
      pt_r = rand128();
      run_block($sformatf("rand14_%0d", k), 1'b1, encrypt(pt_r, 14), pt_r, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES inverse cipher (decryption) core; one inverse round per clock.
- Consumes round keys from the key expander's round-key store by index, in reverse order (NR down to 0).
- Sits opposite the forward round datapath; recovers plaintext from ciphertext produced by it.
- Start/busy/done handshake toward the host; registered 128-bit result.

Parameters:
- NR, 10, number of rounds; legal values 10/12/14 (AES-128/192/256); other values are a compile-time error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request decryption of ct_in; accepted only in IDLE.
- ct_in  input  128  ciphertext; byte0 = [127:120], FIPS-197 column-major order; sampled on the accepting edge only.
- rk_idx  output  4  round-key index requested this cycle; combinational from FSM state/counter.
- rk_in  input  128  round key for rk_idx, same-cycle (combinational lookup in the key store).
- pt_out  output  128  plaintext; registered; holds until the next completion.
- busy  output  1  high from the cycle after acceptance until done asserts.
- done  output  1  one-cycle pulse; pt_out is valid in the same cycle.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE, state reg=0, round counter=0.
  - pt_out=0, busy=0, done=0.
  - Reset mid-operation discards the operation; no done pulse follows.
- FSM states: IDLE, RUN, LAST.
- IDLE:
  - rk_idx=NR.
  - On an edge with start=1: state <= ct_in ^ rk_in; cnt <= NR-1; go RUN; busy<=1.
- RUN:
  - rk_idx=cnt.
  - Each edge: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_in).
  - cnt decrements; when cnt==1 at the edge, go LAST (cnt<=0).
- LAST:
  - rk_idx=0.
  - Edge: pt_out <= InvSubBytes(InvShiftRows(state)) ^ rk_in; done<=1; busy<=0; go IDLE.
- done is a single-cycle pulse and deasserts on the next edge.
- Latency: done asserts NR edges after the accepting edge (10 for AES-128), measured as the edge count from acceptance.
- Throughput: one block per NR+1 cycles, because a new start is accepted in the cycle done is high (FSM is IDLE).
- start while busy=1 is ignored and has no side effects; ct_in is not re-sampled.
- start held high continuously: a new block is accepted each time the FSM is IDLE.
- Arithmetic:
  - GF(2^8) with polynomial 0x11B.
  - InvMixColumns uses coefficients {0e,0b,0d,09}.
  - All XORs are full 128-bit with no truncation.
- rk_idx stays in range 0..NR; it never wraps.
- pt_out is not cleared by a new start; it updates only on completion.

Decomposition:
- Package aes_pkg:
  - inverse S-box constant table.
  - GF helper functions (xtime, mul9, mul11, mul13, mul14).
  - FSM state enum.
  - NR legality check.
- Sub-module inv_round (combinational):
  - Inputs: state_in[127:0], rk[127:0], last.
  - Function: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns bypassed when last=1.
  - The FSM/counter top instantiates it once.

Test Plan:
- FIPS-197 App. C.1 (AES-128):
  - Stimulus: bench key store expanded from key 000102030405060708090a0b0c0d0e0f; ct_in=69c4e0d86a7b0430d8cdb78070b4c55a; pulse start.
  - Response: done after exactly 10 edges; pt_out=00112233445566778899aabbccddeeff.
- FIPS-197 App. B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; ct_in=3925841d02dc09fbdc118597196a0b32.
  - Response: pt_out=3243f6a8885a308d313198a2e0370734.
  - Also check rk_idx sequence 10,9,...,1,0 on consecutive cycles.
- Start while busy:
  - Stimulus: assert start with a different ct_in at cycle 4 of an operation.
  - Response: ignored; pt_out matches the first vector; exactly one done pulse.
- Back-to-back:
  - Stimulus: hold start=1 with vector B then vector C.1.
  - Response: second acceptance in the done cycle; both results correct; done pulses 11 cycles apart.
- Async reset:
  - Stimulus: rst_n low at cycle 5 of an operation, released mid-cycle.
  - Response: outputs go to 0 immediately, without waiting for a clock edge; no done pulse; a subsequent start decrypts correctly.
- NR=14 build:
  - Stimulus: FIPS-197 C.3 key 000102...1f; ct_in=8ea2b7ca516745bfeafc49904b496089.
  - Response: pt_out=00112233445566778899aabbccddeeff after 14 edges.
